// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM state
// encodings and the request legality check used at accept time.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_READ    = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_WRITE   = 3'd3;
  localparam state_t ST_RESP    = 3'd4;

  // Unsigned widths exist only for loads; alignment is checked per width.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for a word-granular memory: extracts and extends load data,
// and merges the low byte/half of store data into the word read back.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // NOTE: every output of a combinational block gets a default before the
  // case so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    lane_b   = word[{addr_lo, 3'b000} +: 8];
    lane_h   = addr_lo[1] ? word[31:16] : word[15:0];
    load_val = word;
    merged   = wdata;
    case (funct3)
      F3_B:  load_val = {{24{lane_b[7]}}, lane_b};
      F3_BU: load_val = {24'b0, lane_b};
      F3_H:  load_val = {{16{lane_h[15]}}, lane_h};
      F3_HU: load_val = {16'b0, lane_h};
      default: ;
    endcase
    case (funct3)
      F3_B: begin
        merged = word;
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      F3_H: merged = addr_lo[1] ? {wdata[15:0], word[15:0]}
                                : {word[31:16], wdata[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding RV32I load/store controller in front of a word-wide
// memory with one-cycle registered reads; sub-word stores use read-modify-write.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] wr_word_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_legal;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept    = req_valid && (state_q == ST_IDLE);
  assign req_legal = is_legal(req_we, req_funct3, req_addr[1:0]);

  // mem_rdata is only meaningful in CAPTURE, the only state that consumes these.
  lsu_align u_align (
    .funct3   (f3_q),
    .addr_lo  (addr_q[1:0]),
    .word     (mem_rdata),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (!req_legal)                        state_d = ST_RESP;
          else if (req_we && req_funct3 == F3_W) state_d = ST_WRITE;
          else                                   state_d = ST_READ;
        end
      end
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = we_q ? ST_WRITE : ST_RESP;
      ST_WRITE:   state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_word_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= ~req_legal;
        rdata_q <= '0;
        if (req_we) wr_word_q <= req_wdata;
      end
      if (state_q == ST_CAPTURE) begin
        if (we_q) wr_word_q <= merged;
        else      rdata_q   <= load_val;
      end
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign mem_re     = (state_q == ST_READ);
  assign mem_we     = (state_q == ST_WRITE);
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = wr_word_q;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a registered-read word memory model;
// each scenario task drives one feature and checks cycle-exact behaviour.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  logic overlap_seen = 1'b0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory model: registered read, write on the edge after the strobe.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr[7:2]];
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  always @(negedge clk) if (mem_re && mem_we) overlap_seen = 1'b1;

  // Starts in an IDLE cycle (cycle 0), ends in the IDLE cycle after RESP.
  task automatic run_op(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int resp_cyc, output logic [31:0] rdata,
                        output logic err, output logic [7:0] re_mask,
                        output logic [7:0] we_mask, output logic [31:0] wr_data,
                        output logic [31:0] wr_addr);
    resp_cyc = -1; rdata = '0; err = 1'b0; re_mask = '0; we_mask = '0;
    wr_data = '0; wr_addr = '0;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    for (int cyc = 1; cyc < 8; cyc++) begin
      @(negedge clk);
      if (cyc == 1) req_valid = 1'b0;
      re_mask[cyc] = mem_re;
      we_mask[cyc] = mem_we;
      if (mem_we) begin
        wr_data = mem_wdata;
        wr_addr = mem_addr;
      end
      if (resp_valid) begin
        resp_cyc = cyc;
        rdata    = resp_rdata;
        err      = resp_err;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 ||
        resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_resp got ready=%b busy=%b rv=%b err=%b rdata=%h exp 1 0 0 0 0",
               req_ready, busy, resp_valid, resp_err, resp_rdata);
    end
    checks++;
    if (mem_re !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_mem got re=%b we=%b addr=%h wdata=%h exp 0 0 0 0",
               mem_re, mem_we, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loads();
    logic [2:0]  f3s   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] addrs [6] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10, 32'h11};
    logic [31:0] exps  [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                               32'h000080FF, 32'h80FF7F01, 32'h0000007F};
    int rc; logic [31:0] rd, wd, wa; logic er; logic [7:0] rm, wm;
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, f3s[i], addrs[i], 32'h0, rc, rd, er, rm, wm, wd, wa);
      checks++;
      if (rc !== 3 || rd !== exps[i] || er !== 1'b0) begin
        failures++;
        $display("FAIL load[%0d] got cyc=%0d rdata=%h err=%b exp cyc=3 rdata=%h err=0",
                 i, rc, rd, er, exps[i]);
      end
      checks++;
      if (rm !== 8'b0000_0010 || wm !== 8'b0) begin
        failures++;
        $display("FAIL load_strobes[%0d] got re=%b we=%b exp re=00000010 we=00000000",
                 i, rm, wm);
      end
    end
  endtask

  task automatic test_back_to_back();
    int r1 = -1, r2 = -1;
    logic [31:0] d1 = '0, d2 = '0;
    logic ready4 = 1'b0;
    logic addr_ok = 1'b1;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = '0;
    req_valid = 1'b1;
    for (int cyc = 1; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        req_funct3 = 3'b100; req_addr = 32'h12;
      end
      if (cyc <= 3 && mem_addr !== 32'h10) addr_ok = 1'b0;
      if (cyc == 4) ready4 = req_ready;
      if (cyc == 5) req_valid = 1'b0;
      if (resp_valid && r1 < 0) begin
        r1 = cyc; d1 = resp_rdata;
      end else if (resp_valid) begin
        r2 = cyc; d2 = resp_rdata;
      end
    end
    checks++;
    if (r1 !== 3 || d1 !== 32'h80FF7F01) begin
      failures++;
      $display("FAIL b2b_first got cyc=%0d rdata=%h exp cyc=3 rdata=80ff7f01", r1, d1);
    end
    checks++;
    if (ready4 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready got %b exp 1", ready4);
    end
    checks++;
    if (r2 !== 7 || d2 !== 32'h000000FF) begin
      failures++;
      $display("FAIL b2b_second got cyc=%0d rdata=%h exp cyc=7 rdata=000000ff", r2, d2);
    end
    checks++;
    if (addr_ok !== 1'b1) begin
      failures++;
      $display("FAIL b2b_addr_hold got changed exp 00000010 held");
    end
  endtask

  task automatic test_sub_word_store();
    int rc; logic [31:0] rd, wd, wa; logic er; logic [7:0] rm, wm;
    mem[4] = 32'h11223344;
    run_op(1'b1, 3'b000, 32'h11, 32'h000000AB, rc, rd, er, rm, wm, wd, wa);
    checks++;
    if (rc !== 4 || er !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL sb_resp got cyc=%0d err=%b rdata=%h exp 4 0 0", rc, er, rd);
    end
    checks++;
    if (rm !== 8'b0000_0010 || wm !== 8'b0000_1000 || wd !== 32'h1122AB44 ||
        wa !== 32'h10) begin
      failures++;
      $display("FAIL sb_mem got re=%b we=%b wdata=%h addr=%h exp 00000010 00001000 1122ab44 10",
               rm, wm, wd, wa);
    end
    checks++;
    if (mem[4] !== 32'h1122AB44) begin
      failures++;
      $display("FAIL sb_word got %h exp 1122ab44", mem[4]);
    end
    mem[5] = 32'hAABBCCDD;
    run_op(1'b1, 3'b001, 32'h16, 32'hFFFF5566, rc, rd, er, rm, wm, wd, wa);
    checks++;
    if (rc !== 4 || er !== 1'b0 || wd !== 32'h5566CCDD || wm !== 8'b0000_1000) begin
      failures++;
      $display("FAIL sh_merge got cyc=%0d err=%b wdata=%h we=%b exp 4 0 5566ccdd 00001000",
               rc, er, wd, wm);
    end
  endtask

  task automatic test_word_store();
    int rc; logic [31:0] rd, wd, wa; logic er; logic [7:0] rm, wm;
    run_op(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, rc, rd, er, rm, wm, wd, wa);
    checks++;
    if (rc !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL sw_resp got cyc=%0d err=%b rdata=%h exp 2 0 0", rc, er, rd);
    end
    checks++;
    if (rm !== 8'b0 || wm !== 8'b0000_0010 || wa !== 32'h20 || wd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sw_mem got re=%b we=%b addr=%h wdata=%h exp 00000000 00000010 20 deadbeef",
               rm, wm, wa, wd);
    end
    checks++;
    if (mem[8] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sw_word got %h exp deadbeef", mem[8]);
    end
  endtask

  task automatic test_errors();
    logic        wes   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s   [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] addrs [4] = '{32'h22, 32'h03, 32'h10, 32'h10};
    int rc; logic [31:0] rd, wd, wa; logic er; logic [7:0] rm, wm;
    for (int i = 0; i < 4; i++) begin
      run_op(wes[i], f3s[i], addrs[i], 32'h12345678, rc, rd, er, rm, wm, wd, wa);
      checks++;
      if (rc !== 1 || er !== 1'b1 || rd !== 32'h0 || rm !== 8'b0 || wm !== 8'b0) begin
        failures++;
        $display("FAIL err[%0d] got cyc=%0d err=%b rdata=%h re=%b we=%b exp 1 1 0 0 0",
                 i, rc, er, rd, rm, wm);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic stray = 1'b0;
    mem[12] = 32'hCAFEF00D;
    req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h30; req_wdata = 32'h7777;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_re !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_capture got re=%b busy=%b exp 0 1", mem_re, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got ready=%b busy=%b we=%b rv=%b exp 1 0 0 0",
               req_ready, busy, mem_we, resp_valid);
    end
    reset = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (mem_we || resp_valid || mem_re) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0 || mem[12] !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL mid_after got stray=%b word=%h exp 0 cafef00d", stray, mem[12]);
    end
  endtask

  task automatic test_strobes();
    checks++;
    if (overlap_seen !== 1'b0) begin
      failures++;
      $display("FAIL strobe_overlap got 1 exp 0");
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h80FF7F01;
    mem_rdata = '0;
    test_reset();
    test_loads();
    test_back_to_back();
    test_sub_word_store();
    test_word_store();
    test_errors();
    test_reset_mid_op();
    test_strobes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
